// File: rtl/ts_sync_lock.sv
// ts_sync_lock: per-stream TS byte aligner with lock/unlock hysteresis and a
// flywheel packet boundary marker.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   byte_in, byte_valid  incoming stream byte and its qualifier
//   byte_out, valid_out  registered copy of the input byte (0 when not valid)
//   sop                  byte_out is packet byte 0 (only while locked)
//   pkt_idx              index of byte_out in its packet, 0 when not locked
//   locked               lock status
//   sync_err             one-cycle pulse on a missed sync slot while locked
//   lost_cnt             saturating count of LOCKED->HUNT transitions
//
// Latency is one cycle. There is no backpressure: one byte is accepted on
// every cycle with byte_valid high.
//
// Build option: define TS_SYNC_INV_EN to also accept ~SYNC_BYTE as a sync
// byte (the inverted sync that DVB energy dispersal puts in every 8th packet).
module ts_sync_lock #(
  parameter int         PKT_LEN    = 188,
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         LOCK_CNT   = 5,
  parameter int         UNLOCK_CNT = 3,
  parameter int         IDX_W      = 8,
  parameter int         ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic [7:0]       byte_out,
  output logic             valid_out,
  output logic             sop,
  output logic [IDX_W-1:0] pkt_idx,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] lost_cnt
);

  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [IDX_W-1:0]  POS_LAST   = IDX_W'(PKT_LEN - 1);
  localparam logic [HIT_W-1:0]  LOCK_TGT   = HIT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] UNLOCK_TGT = MISS_W'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    S_HUNT,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_pos;
  logic [HIT_W-1:0]  r_hit;
  logic [MISS_W-1:0] r_miss;
  logic [ERR_W-1:0]  r_lost;
  logic [7:0]        r_byte_out;
  logic              r_valid_out;
  logic              r_sop;
  logic [IDX_W-1:0]  r_idx;
  logic              r_locked;
  logic              r_err;

  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_pos_nxt;
  logic [HIT_W-1:0]  w_hit_nxt;
  logic [MISS_W-1:0] w_miss_nxt;
  logic [ERR_W-1:0]  w_lost_nxt;
  logic              w_sop_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_locked_nxt;
  logic              w_err_nxt;

  logic              w_is_sync;
  logic              w_slot;
  logic [IDX_W-1:0]  w_pos_inc;
  logic [HIT_W-1:0]  w_hit_inc;
  logic [MISS_W-1:0] w_miss_inc;
  logic [ERR_W-1:0]  w_lost_sat;

`ifdef TS_SYNC_INV_EN
  assign w_is_sync = (byte_in == SYNC_BYTE) || (byte_in == ~SYNC_BYTE);
`else
  assign w_is_sync = (byte_in == SYNC_BYTE);
`endif

  // r_pos is the position of the byte currently on byte_in (VERIFY/LOCKED).
  assign w_slot     = (r_pos == '0);
  assign w_pos_inc  = (r_pos == POS_LAST) ? '0 : r_pos + IDX_W'(1);
  assign w_hit_inc  = r_hit + HIT_W'(1);
  assign w_miss_inc = r_miss + MISS_W'(1);
  assign w_lost_sat = (r_lost == '1) ? r_lost : r_lost + ERR_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_hit_nxt    = r_hit;
    w_miss_nxt   = r_miss;
    w_lost_nxt   = r_lost;
    w_sop_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_idx_nxt    = r_idx;
    w_locked_nxt = r_locked;

    if (byte_valid) begin
      case (r_state)
        S_HUNT: begin
          w_idx_nxt    = '0;
          w_locked_nxt = 1'b0;
          if (w_is_sync) begin
            // This byte is the candidate's position 0; the next one is 1.
            w_pos_nxt = IDX_W'(1);
            w_hit_nxt = HIT_W'(1);
            if (LOCK_CNT == 1) begin
              w_state_nxt  = S_LOCKED;
              w_sop_nxt    = 1'b1;
              w_locked_nxt = 1'b1;
            end else begin
              w_state_nxt = S_VERIFY;
            end
          end
        end

        S_VERIFY: begin
          w_pos_nxt    = w_pos_inc;
          w_idx_nxt    = '0;
          w_locked_nxt = 1'b0;
          if (w_slot) begin
            if (w_is_sync) begin
              w_hit_nxt = w_hit_inc;
              if (w_hit_inc == LOCK_TGT) begin
                w_state_nxt  = S_LOCKED;
                w_sop_nxt    = 1'b1;
                w_locked_nxt = 1'b1;
              end
            end else begin
              // The failing byte is not taken as a fresh candidate.
              w_state_nxt = S_HUNT;
              w_hit_nxt   = '0;
            end
          end
        end

        S_LOCKED: begin
          w_pos_nxt    = w_pos_inc;
          w_idx_nxt    = r_pos;
          w_locked_nxt = 1'b1;
          if (w_slot) begin
            w_sop_nxt = 1'b1;
            if (w_is_sync) begin
              w_miss_nxt = '0;
            end else begin
              w_err_nxt = 1'b1;
              if (w_miss_inc == UNLOCK_TGT) begin
                w_state_nxt  = S_HUNT;
                w_sop_nxt    = 1'b0;
                w_idx_nxt    = '0;
                w_locked_nxt = 1'b0;
                w_miss_nxt   = '0;
                w_hit_nxt    = '0;
                w_lost_nxt   = w_lost_sat;
              end else begin
                w_miss_nxt = w_miss_inc;
              end
            end
          end
        end

        default: begin
          w_state_nxt  = S_HUNT;
          w_idx_nxt    = '0;
          w_locked_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos       <= '0;
      r_hit       <= '0;
      r_miss      <= '0;
      r_lost      <= '0;
      r_byte_out  <= 8'h00;
      r_valid_out <= 1'b0;
      r_sop       <= 1'b0;
      r_idx       <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pos       <= w_pos_nxt;
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_lost      <= w_lost_nxt;
      r_byte_out  <= byte_valid ? byte_in : 8'h00;
      r_valid_out <= byte_valid;
      r_sop       <= w_sop_nxt;
      r_idx       <= w_idx_nxt;
      r_locked    <= w_locked_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign byte_out  = r_byte_out;
  assign valid_out = r_valid_out;
  assign sop       = r_sop;
  assign pkt_idx   = r_idx;
  assign locked    = r_locked;
  assign sync_err  = r_err;
  assign lost_cnt  = r_lost;

endmodule

// File: tb/tb_ts_sync_lock.sv
// tb_ts_sync_lock: drives one byte stream into two ts_sync_lock instances
// (defaults, and PKT_LEN=204 / LOCK_CNT=1 / UNLOCK_CNT=1) and scores every
// output cycle against a byte-count based reference model.
module tb_ts_sync_lock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;

  logic [7:0]  a_byte_out, b_byte_out;
  logic        a_valid_out, b_valid_out;
  logic        a_sop, b_sop;
  logic [7:0]  a_idx, b_idx;
  logic        a_locked, b_locked;
  logic        a_err, b_err;
  logic [15:0] a_lost, b_lost;

  always #5 clk = ~clk;

  ts_sync_lock u_a (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_out(a_byte_out), .valid_out(a_valid_out), .sop(a_sop),
    .pkt_idx(a_idx), .locked(a_locked), .sync_err(a_err), .lost_cnt(a_lost)
  );

  ts_sync_lock #(.PKT_LEN(204), .LOCK_CNT(1), .UNLOCK_CNT(1)) u_b (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_out(b_byte_out), .valid_out(b_valid_out), .sop(b_sop),
    .pkt_idx(b_idx), .locked(b_locked), .sync_err(b_err), .lost_cnt(b_lost)
  );

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic       sop;
    int         idx;
    logic       lk;
    logic       err;
    int         lost;
  } exp_t;

  // Reference state: n counts valid bytes, anchor is the byte number of the
  // current sync candidate, so a byte's packet position is (n-anchor)%len.
  typedef struct {
    int n;
    int anchor;
    int streak;
    int misses;
    int idx;
    int lost;
    bit lk;
    bit hunting;
  } mdl_t;

  exp_t qa[$];
  exp_t qb[$];
  mdl_t ma, mb;

  int checks = 0;
  int errors = 0;

  // monitor statistics, cleared while reset is held
  int vcnt_a, vcnt_b, lock_idx_a, lock_idx_b, erra;
  bit lk_prev_a, lk_prev_b;

  bit gap_en = 1'b0;
  int gcnt = 0;

  function automatic bit is_sync(input logic [7:0] b);
`ifdef TS_SYNC_INV_EN
    return (b == 8'h47) || (b == 8'hB8);
`else
    return (b == 8'h47);
`endif
  endfunction

  task automatic step(inout mdl_t m, input int len, input int lkc, input int ulc,
                      input bit v, input logic [7:0] b, output exp_t e);
    bit s;
    int pos;
    e.b   = v ? b : 8'h00;
    e.v   = v;
    e.sop = 1'b0;
    e.err = 1'b0;
    if (v) begin
      s = is_sync(b);
      if (m.hunting) begin
        m.idx = 0;
        if (s) begin
          m.anchor  = m.n;
          m.streak  = 1;
          m.hunting = 1'b0;
          if (m.streak >= lkc) begin
            m.lk  = 1'b1;
            e.sop = 1'b1;
          end
        end
      end else begin
        pos = (m.n - m.anchor) % len;
        if (!m.lk) begin
          m.idx = 0;
          if (pos == 0) begin
            if (s) begin
              m.streak++;
              if (m.streak == lkc) begin
                m.lk  = 1'b1;
                e.sop = 1'b1;
              end
            end else begin
              m.hunting = 1'b1;
              m.streak  = 0;
            end
          end
        end else begin
          m.idx = pos;
          if (pos == 0) begin
            e.sop = 1'b1;
            if (s) begin
              m.misses = 0;
            end else begin
              e.err = 1'b1;
              m.misses++;
              if (m.misses == ulc) begin
                m.lk      = 1'b0;
                m.hunting = 1'b1;
                m.misses  = 0;
                m.idx     = 0;
                e.sop     = 1'b0;
                if (m.lost < 65535) m.lost++;
              end
            end
          end
        end
      end
      m.n++;
    end
    e.idx  = m.idx;
    e.lk   = m.lk;
    e.lost = m.lost;
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [7:0] bo, input logic vo,
                     input logic so, input int idx, input logic lk, input logic er, input int lo);
    checks++;
    if (e.b !== bo || e.v !== vo || e.sop !== so || e.idx != idx ||
        e.lk !== lk || e.err !== er || e.lost != lo) begin
      errors++;
      $display("FAIL %s t=%0t got b=%h v=%b sop=%b idx=%0d lk=%b err=%b lost=%0d want b=%h v=%b sop=%b idx=%0d lk=%b err=%b lost=%0d",
               nm, $time, bo, vo, so, idx, lk, er, lo, e.b, e.v, e.sop, e.idx, e.lk, e.err, e.lost);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // monitor: one expectation per driven cycle, compared just after the edge
  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        qa.delete();
        qb.delete();
        vcnt_a = 0; vcnt_b = 0; lock_idx_a = -1; lock_idx_b = -1; erra = 0;
        lk_prev_a = 1'b0; lk_prev_b = 1'b0;
      end else if (qa.size() > 0 && qb.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        cmp("out_a", ea, a_byte_out, a_valid_out, a_sop, int'(a_idx), a_locked, a_err, int'(a_lost));
        cmp("out_b", eb, b_byte_out, b_valid_out, b_sop, int'(b_idx), b_locked, b_err, int'(b_lost));
        if (a_valid_out) begin
          if (a_locked && !lk_prev_a && lock_idx_a < 0) lock_idx_a = vcnt_a;
          if (a_err) erra++;
          vcnt_a++;
        end
        if (b_valid_out) begin
          if (b_locked && !lk_prev_b && lock_idx_b < 0) lock_idx_b = vcnt_b;
          vcnt_b++;
        end
        lk_prev_a = a_locked;
        lk_prev_b = b_locked;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic send(input bit v, input logic [7:0] b);
    exp_t ea, eb;
    @(negedge clk);
    byte_valid = v;
    byte_in    = b;
    step(ma, 188, 5, 3, v, b, ea);
    step(mb, 204, 1, 1, v, b, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  // one valid byte, followed by an idle cycle after every second byte in gap mode
  task automatic sendv(input logic [7:0] b);
    send(1'b1, b);
    if (gap_en) begin
      gcnt++;
      if (gcnt == 2) begin
        gcnt = 0;
        send(1'b0, 8'($urandom_range(1, 255)));
      end
    end
  endtask

  function automatic logic [7:0] pay();
    logic [7:0] r;
    r = 8'($urandom);
    while (r == 8'h47 || r == 8'hB8) r = 8'($urandom);
    return r;
  endfunction

  // async reset in mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (a_byte_out !== 8'h00 || a_valid_out !== 1'b0 || a_sop !== 1'b0 || a_idx !== 8'h00 ||
        a_locked !== 1'b0 || a_err !== 1'b0 || a_lost !== 16'h0000 ||
        b_byte_out !== 8'h00 || b_valid_out !== 1'b0 || b_sop !== 1'b0 || b_idx !== 8'h00 ||
        b_locked !== 1'b0 || b_err !== 1'b0 || b_lost !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got a=%h/%b/%b/%0d/%b/%b/%0d b=%h/%b/%b/%0d/%b/%b/%0d want all zero",
               a_byte_out, a_valid_out, a_sop, a_idx, a_locked, a_err, a_lost,
               b_byte_out, b_valid_out, b_sop, b_idx, b_locked, b_err, b_lost);
    end
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    ma = '{default: 0};
    ma.hunting = 1'b1;
    mb = '{default: 0};
    mb.hunting = 1'b1;
    gcnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic finish_phase();
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] sb;
    do_reset();

    // clean stream, then 2 and 3 consecutive corrupted slots
    for (int i = 0; i < 6 * 188; i++) sendv((i % 188 == 0) ? 8'h47 : pay());
    for (int p = 6; p < 12; p++)
      for (int j = 0; j < 188; j++)
        sendv((j == 0) ? ((p == 8 || p == 9) ? 8'h47 : 8'h00) : pay());
    for (int j = 0; j < 11; j++) sendv((j == 0) ? 8'h00 : pay());
    finish_phase();
    chk("clean_lock_byte", lock_idx_a, 752);
    chk("corrupt_err_pulses", erra, 5);
    chk("corrupt_locked", int'(a_locked), 0);
    chk("corrupt_lost_cnt", int'(a_lost), 1);
    do_reset();

    // false candidate at byte 10, true syncs from byte 300
    for (int i = 0; i < 300 + 6 * 188; i++)
      sendv((i == 10 || (i >= 300 && (i - 300) % 188 == 0)) ? 8'h47 : pay());
    finish_phase();
    chk("false_cand_lock_byte", lock_idx_a, 1052);
    chk("false_cand_locked", int'(a_locked), 1);
    do_reset();

    // clean stream with one idle cycle in three
    gap_en = 1'b1;
    for (int i = 0; i < 6 * 188; i++) sendv((i % 188 == 0) ? 8'h47 : pay());
    gap_en = 1'b0;
    finish_phase();
    chk("gap_lock_byte", lock_idx_a, 752);
    do_reset();

    // 204-byte packets, one missed slot, reset mid-packet while locked
    for (int i = 0; i < 4 * 204 + 50; i++)
      sendv((i % 204 == 0) ? ((i == 408) ? 8'h00 : 8'h47) : pay());
    @(posedge clk);
    #2;
    chk("rs_first_lock_byte", lock_idx_b, 0);
    chk("rs_lost_cnt", int'(b_lost), 1);
    chk("rs_relocked", int'(b_locked), 1);
    chk("rs_valid_before_reset", int'(b_valid_out), 1);
    do_reset();

    // inverted sync in every 8th packet
    for (int p = 0; p < 20; p++)
      for (int j = 0; j < 188; j++)
        sendv((j == 0) ? ((p % 8 == 7) ? 8'hB8 : 8'h47) : pay());
    finish_phase();
`ifdef TS_SYNC_INV_EN
    chk("inv_err_pulses", erra, 0);
`else
    chk("inv_err_pulses", erra, 2);
`endif
    chk("inv_locked", int'(a_locked), 1);
    chk("inv_lost_cnt", int'(a_lost), 0);
    do_reset();

    // randomized: mostly-good 188 framing, noisy slots, random payload and gaps
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) send(1'b0, 8'($urandom));
      if (i % 188 == 0) begin
        case ($urandom_range(0, 9))
          0:       sb = 8'hB8;
          1, 2:    sb = 8'($urandom);
          default: sb = 8'h47;
        endcase
      end else begin
        sb = ($urandom_range(0, 49) == 0) ? 8'h47 : 8'($urandom);
      end
      send(1'b1, sb);
    end
    finish_phase();
    chk("queue_drained", qa.size() + qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_sync_lock.md
Name: ts_sync_lock

Overview:
- Parametrised successor of the single-channel TS sync recovery stage: per-stream byte aligner with configurable packet length, sync byte and lock/unlock hysteresis.
- Sits between the byte deserialiser and the TS packet parser, one instance per input stream.
- Provides a flywheel packet boundary marker (sop), byte index within the packet, a lock flag, a sync-error pulse and a loss-of-lock counter for QoS monitoring.

Parameters:
PKT_LEN, 188, packet length in bytes (204 for RS-coded streams); legal range 2..2**IDX_W.
SYNC_BYTE, 8'h47, sync byte value.
LOCK_CNT, 5, consecutive correctly spaced syncs needed to declare lock (>=1), counting the first candidate.
UNLOCK_CNT, 3, consecutive missed sync slots that drop lock (>=1).
IDX_W, 8, width of the byte index counter.
ERR_W, 16, width of the loss-of-lock counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
byte_in  input  8  stream byte
byte_valid  input  1  byte_in qualifier
byte_out  output  8  registered copy of byte_in
valid_out  output  1  registered byte_valid
sop  output  1  byte_out is packet byte 0 (locked only)
pkt_idx  output  IDX_W  index of byte_out in packet, 0 when not locked
locked  output  1  lock status
sync_err  output  1  one-cycle pulse: sync slot mismatch while locked
lost_cnt  output  ERR_W  saturating count of LOCKED->HUNT transitions

Behaviour:
- Reset (async, rst=0): state HUNT, all counters 0. Outputs: byte_out=0, valid_out=0, sop=0, pkt_idx=0, locked=0, sync_err=0, lost_cnt=0.
- Latency is 1 cycle. Every output describes the byte presented on the previous clock edge.
- byte_valid=0: no state or counter advances. valid_out=0, byte_out=0, sop=0, sync_err=0. locked, pkt_idx and lost_cnt hold.
- State and counters advance only on valid bytes. A position counter runs 0..PKT_LEN-1 and wraps to 0. Slot = position 0.
- HUNT:
  - byte_in==SYNC_BYTE: position:=1, hit:=1, go to VERIFY.
  - If LOCK_CNT==1, go directly to LOCKED instead, with sop asserted on this byte.
- VERIFY:
  - Advance position.
  - At the slot, byte==SYNC_BYTE: hit++. When hit reaches LOCK_CNT, go to LOCKED; locked and sop assert together with this byte's valid_out.
  - At the slot, mismatch: go to HUNT, hit:=0. The mismatching byte is not re-examined as a new candidate.
  - Payload bytes are never examined for sync.
- LOCKED:
  - sop=1 and pkt_idx=0 on every slot byte (flywheel); pkt_idx tracks position.
  - Slot match: miss:=0.
  - Slot mismatch with miss+1 < UNLOCK_CNT: miss++, sync_err=1, sop still asserted.
  - Slot mismatch with miss+1 == UNLOCK_CNT: go to HUNT. locked=0, sop=0, sync_err=1 and pkt_idx=0 on that byte. lost_cnt++ (saturates at all-ones). miss:=0.
- lost_cnt clears only on reset.
- Reset mid-packet or mid-lock aborts immediately to the HUNT/reset values.

Optional Feature:
- Macro TS_SYNC_INV_EN.
- Defined: ~SYNC_BYTE (8'hB8 for default) is accepted as a valid sync in all states (DVB energy-dispersal inverted sync every 8th packet), with identical timing to SYNC_BYTE.
- Undefined: 8'hB8 is an ordinary byte. At a slot it counts as a mismatch.

Test Plan:
- Defaults, clean stream of 6 packets (first byte 0x47): locked and sop rise with valid_out of byte 752 (4*188). pkt_idx=0 there and at byte 940. sync_err never pulses.
- While locked, corrupt 2 consecutive slots to 0x00: 2 sync_err pulses, locked stays 1, sop still at both slots. Corrupt 3 consecutive: locked falls on the 3rd slot, lost_cnt=1.
- HUNT with 0x47 at byte 10 and no 0x47 at byte 198, true syncs from byte 300: returns to HUNT at 198. Lock is declared at byte 300+4*188=1052.
- Same clean stream with byte_valid low for 1 of every 3 cycles: lock on the identical byte count. Outputs are 0 (valid_out/byte_out/sop) during gaps.
- PKT_LEN=204, LOCK_CNT=1, UNLOCK_CNT=1: locked on the first 0x47. A single slot miss drops lock and sets lost_cnt=1. Assert rst low mid-packet: all outputs return to 0 asynchronously.
- TS_SYNC_INV_EN defined, every 8th sync replaced by 0xB8: no sync_err, lock is held. Same stimulus without the macro: sync_err on each 0xB8 slot, lock held (isolated misses).
